// File: rtl/fml_memtest_pkg.sv
// Shared definitions for the FML memory tester: FSM encoding, burst geometry
// and the pattern-generator polynomial.
package fml_memtest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DATA,
        RD_REQ,
        RD_DATA,
        FINISH
    } state_t;

    localparam int          BURST_BEATS = 4;
    localparam int          BURST_BYTES = 16;
    localparam logic [31:0] LFSR_MASK   = 32'h80200003;

    // One step of the right-shifting Galois LFSR, x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/fml_memtest_lfsr.sv
// 32-bit Galois LFSR pattern source. A zero seed would lock the register at
// zero, so it is replaced with 1 on load. Load wins over advance.
module fml_memtest_lfsr
    import fml_memtest_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] q
);

    // Pattern register: reload on load, step once per advance.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its neighbours.
        if (sys_rst) begin
            q <= 32'h00000001;
        end else if (load) begin
            q <= (seed == 32'h0) ? 32'h00000001 : seed;
        end else if (advance) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/fml_memtest.sv
// FML memory tester: writes an LFSR pattern over a range of 16-byte bursts,
// reads it back, and counts mismatching 32-bit beats.
// Optional feature macro: FML_MEMTEST_FIRST_ERR_EN -- when defined, the byte
// address of the first mismatching beat is captured on first_err_adr;
// otherwise first_err_adr is tied to 0.
module fml_memtest
    import fml_memtest_pkg::*;
#(
    parameter int sdram_depth = 26,
    parameter int len_width   = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic [sdram_depth-1:0] base_adr,
    input  logic [len_width-1:0]   bursts,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            err_count,
    output logic [sdram_depth-1:0] first_err_adr,
    output logic [sdram_depth-1:0] fml_adr,
    output logic                   fml_stb,
    output logic                   fml_we,
    input  logic                   fml_ack,
    output logic [3:0]             fml_sel,
    output logic [31:0]            fml_do,
    input  logic [31:0]            fml_di
);

    state_t                 state;
    state_t                 state_next;
    logic [sdram_depth-1:0] base;
    logic [sdram_depth-1:0] adr;
    logic [len_width-1:0]   bursts_r;
    logic [len_width-1:0]   remaining;
    logic [1:0]             beat;
    logic [31:0]            seed_r;
    logic [31:0]            err_cnt;

    logic                   lfsr_load;
    logic                   lfsr_advance;
    logic [31:0]            lfsr_seed;
    logic [31:0]            lfsr_q;

    logic [sdram_depth-1:0] base_aligned;
    logic                   last_beat;
    logic                   last_burst;
    logic                   mismatch;
    logic                   write_phase;

    assign base_aligned = base_adr & ~sdram_depth'(BURST_BYTES - 1);
    assign last_beat    = (beat == 2'(BURST_BEATS - 1));
    assign last_burst   = (remaining == len_width'(1));
    assign mismatch     = (state == RD_DATA) && (fml_di != lfsr_q);
    assign write_phase  = (state == WR_REQ) || (state == WR_DATA);
    assign lfsr_seed    = (state == IDLE) ? seed : seed_r;

    fml_memtest_lfsr u_lfsr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (lfsr_load),
        .seed    (lfsr_seed),
        .advance (lfsr_advance),
        .q       (lfsr_q)
    );

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and LFSR control.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next   = state;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (bursts != '0) begin
                        state_next = WR_REQ;
                        lfsr_load  = 1'b1;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            WR_REQ: begin
                if (fml_ack) begin
                    state_next   = WR_DATA;
                    lfsr_advance = 1'b1;
                end
            end
            WR_DATA: begin
                lfsr_advance = 1'b1;
                if (last_beat) begin
                    if (last_burst) begin
                        state_next = RD_REQ;
                        lfsr_load  = 1'b1;
                    end else begin
                        state_next = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (fml_ack) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                lfsr_advance = 1'b1;
                if (last_beat) begin
                    state_next = last_burst ? FINISH : RD_REQ;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latches, burst address/counters, beat counter and error count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            base      <= '0;
            adr       <= '0;
            bursts_r  <= '0;
            remaining <= '0;
            beat      <= '0;
            seed_r    <= '0;
            err_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base      <= base_aligned;
                        adr       <= base_aligned;
                        bursts_r  <= bursts;
                        remaining <= bursts;
                        seed_r    <= seed;
                        err_cnt   <= '0;
                    end
                end
                WR_REQ: begin
                    // Beat 0 goes out in the ack cycle itself.
                    if (fml_ack) begin
                        beat <= 2'd1;
                    end
                end
                WR_DATA: begin
                    beat <= beat + 2'd1;
                    if (last_beat) begin
                        if (last_burst) begin
                            adr       <= base;
                            remaining <= bursts_r;
                        end else begin
                            adr       <= adr + sdram_depth'(BURST_BYTES);
                            remaining <= remaining - len_width'(1);
                        end
                    end
                end
                RD_REQ: begin
                    // Read data starts the cycle after ack.
                    if (fml_ack) begin
                        beat <= 2'd0;
                    end
                end
                RD_DATA: begin
                    beat <= beat + 2'd1;
                    if (mismatch && (err_cnt != 32'hFFFFFFFF)) begin
                        err_cnt <= err_cnt + 32'd1;
                    end
                    if (last_beat && !last_burst) begin
                        adr       <= adr + sdram_depth'(BURST_BYTES);
                        remaining <= remaining - len_width'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FML_MEMTEST_FIRST_ERR_EN
    logic [sdram_depth-1:0] first_err_r;
    logic [sdram_depth-1:0] beat_adr;

    assign beat_adr = adr + sdram_depth'({beat, 2'b00});

    // Capture the byte address of the first mismatching beat of a test.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            first_err_r <= '0;
        end else if ((state == IDLE) && start) begin
            first_err_r <= '0;
        end else if (mismatch && (err_cnt == 32'h0)) begin
            first_err_r <= beat_adr;
        end
    end

    assign first_err_adr = first_err_r;
`else
    assign first_err_adr = '0;
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign err_count = err_cnt;
    assign fml_adr   = adr;
    assign fml_stb   = (state == WR_REQ) || (state == RD_REQ);
    assign fml_we    = (state == WR_REQ);
    assign fml_sel   = write_phase ? 4'hF : 4'h0;
    assign fml_do    = write_phase ? lfsr_q : 32'h0;

endmodule
